// File: rtl/pipelined_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit_if
//   Issue handshake, hazard controls and registered control bundle between
//   the IF/ID stage, the hazard unit and the registered control decoder.
//
//   master : the issuing side (IF/ID + hazard unit). It drives instr,
//            instr_valid, stall and flush.
//   slave  : the control unit. It drives instr_ready, valid_out, illegal,
//            busy and the control bundle.
// ---------------------------------------------------------------------------
interface pipelined_control_unit_if #(
  parameter int ALUOP_W = 5
);
  logic [31:0]        instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               stall;
  logic               flush;
  logic               valid_out;
  logic               illegal;
  logic               busy;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_write;
  logic               alu_src;
  logic               mem_write;
  logic               mem_read;
  logic               branch;
  logic               sign_ext;
  logic               jump;
  logic               jump_mux;

  modport master (
    output instr, instr_valid, stall, flush,
    input  instr_ready, valid_out, illegal, busy,
    input  reg_dst, mem_to_reg, alu_op, reg_write, alu_src,
    input  mem_write, mem_read, branch, sign_ext, jump, jump_mux
  );

  modport slave (
    input  instr, instr_valid, stall, flush,
    output instr_ready, valid_out, illegal, busy,
    output reg_dst, mem_to_reg, alu_op, reg_write, alu_src,
    output mem_write, mem_read, branch, sign_ext, jump, jump_mux
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//   Registered opcode decoder sitting at the ID/EX boundary. instr[31:26] is
//   decoded into the datapath control bundle, which appears one cycle after
//   the instruction is accepted (instr_valid & instr_ready).
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; loads the all-zero NOP bundle
//   bus    : slave modport of pipelined_control_unit_if
//            instr/instr_valid/instr_ready : issue handshake
//            stall : hold every registered output, the counter and the state
//            flush : load NOP next edge and abort any multiply in progress
//            valid_out : bundle valid for ID/EX
//            illegal   : one-cycle pulse when an undefined opcode is accepted
//            busy      : multiply hold in progress
//            reg_dst .. jump_mux, alu_op : control bundle
//
// Multiply timing (MUL_CYCLES = N > 1): the accept edge loads counter = N-1
// and raises busy. The counter steps down on each non-stalled edge; the edge
// that finds it at zero loads the MUL bundle with valid_out = 1 and drops
// busy, so busy is high for N unstalled cycles and the next instruction can
// be accepted in the same cycle the MUL bundle is presented.
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int ALUOP_W    = 5,  // must be >= 5; codes are zero-extended
  parameter int MUL_CYCLES = 4,  // 1..15
  parameter int TRAP_EN    = 1
) (
  input logic                    clk,
  input logic                    reset,
  pipelined_control_unit_if.slave bus
);

  // Control bundle, field order matches the decode table columns.
  typedef struct packed {
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic [1:0] mem_to_reg;
    logic       sign_ext;
    logic [4:0] alu_op;
    logic       jump;
    logic       jump_mux;
  } ctrl_t;

  typedef enum logic {ST_RUN = 1'b0, ST_MUL = 1'b1} state_t;

  // With a one-cycle multiply the MUL state is never entered.
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam bit         TRAP_BIT  = (TRAP_EN != 0);

  function automatic ctrl_t mk(
    input logic [1:0] rd, input logic rw, input logic as, input logic mw,
    input logic mr, input logic br, input logic [1:0] mtr, input logic se,
    input logic [4:0] op, input logic j, input logic jm
  );
    return {rd, rw, as, mw, mr, br, mtr, se, op, j, jm};
  endfunction

  // Conditional branches differ only in the ALU comparison code.
  function automatic ctrl_t br_c(input logic [4:0] op);
    return mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, op, 1'b0, 1'b0);
  endfunction

  // Immediate ALU ops differ only in sign extension and ALU code.
  function automatic ctrl_t imm_c(input logic se, input logic [4:0] op);
    return mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, se, op, 1'b0, 1'b0);
  endfunction

  state_t     state_reg, state_next;
  logic [3:0] count_reg, count_next;
  ctrl_t      ctrl_reg, ctrl_next;
  logic       valid_reg, valid_next;
  logic       illegal_reg, illegal_next;

  ctrl_t      dec_ctrl;
  logic       dec_legal;
  logic       dec_mul;
  ctrl_t      mul_ctrl;
  logic       busy;
  logic       instr_ready;
  logic       acc;
  logic       unused_instr;

  assign unused_instr = ^bus.instr[25:0];
  assign mul_ctrl     = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                           5'b01100, 1'b0, 1'b0);

  assign busy        = (state_reg == ST_MUL);
  assign instr_ready = ~busy & ~bus.stall & ~reset;
  assign acc         = bus.instr_valid & instr_ready;

  // ------------------------------------------------------------------
  // Opcode decoder
  // ------------------------------------------------------------------
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_mul   = 1'b0;
    unique case (bus.instr[31:26])
      6'b000000: dec_ctrl = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                               5'b00000, 1'b0, 1'b1);
      6'b000001: dec_ctrl = br_c(5'b10000);
      6'b000100: dec_ctrl = br_c(5'b01110);
      6'b000101: dec_ctrl = br_c(5'b01111);
      6'b000110: dec_ctrl = br_c(5'b10010);
      6'b000111: dec_ctrl = br_c(5'b10001);
      6'b000010: dec_ctrl = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                               5'b00000, 1'b1, 1'b0);
      6'b000011: dec_ctrl = mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1,
                               5'b00000, 1'b1, 1'b0);
      6'b001000: dec_ctrl = imm_c(1'b1, 5'b00001);
      6'b001001: dec_ctrl = imm_c(1'b0, 5'b00111);
      6'b001010: dec_ctrl = imm_c(1'b1, 5'b01010);
      6'b001011: dec_ctrl = imm_c(1'b1, 5'b01011);
      6'b001100: dec_ctrl = imm_c(1'b1, 5'b00100);
      6'b001101: dec_ctrl = imm_c(1'b1, 5'b00011);
      6'b001110: dec_ctrl = imm_c(1'b1, 5'b00101);
      6'b001111: dec_ctrl = imm_c(1'b0, 5'b10011);
      6'b011111: dec_ctrl = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                               5'b01101, 1'b0, 1'b0);
      6'b100000, 6'b100001, 6'b100011:
        dec_ctrl = mk(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1,
                      5'b00001, 1'b0, 1'b0);
      6'b101000, 6'b101001, 6'b101011:
        dec_ctrl = mk(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1,
                      5'b00001, 1'b0, 1'b0);
      6'b011100: begin
        dec_ctrl = mul_ctrl;
        dec_mul  = 1'b1;
      end
      default:   dec_legal = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: state register (also holds counter and output registers)
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      count_reg   <= '0;
      ctrl_reg    <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      ctrl_reg    <= ctrl_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state / counter
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (bus.flush) begin
      state_next = ST_RUN;
      count_next = '0;
    end else if (!bus.stall) begin
      unique case (state_reg)
        ST_RUN: begin
          if (acc && dec_mul && MUL_MULTI) begin
            state_next = ST_MUL;
            count_next = MUL_LOAD;
          end
        end
        ST_MUL: begin
          if (count_reg == 4'd0) begin
            state_next = ST_RUN;
          end else begin
            count_next = count_reg - 4'd1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // FSM: next registered outputs. Anything not explicitly loaded below
  // falls back to the NOP bundle with valid_out low.
  // ------------------------------------------------------------------
  always_comb begin
    ctrl_next    = ctrl_reg;
    valid_next   = valid_reg;
    illegal_next = illegal_reg;
    if (bus.flush) begin
      ctrl_next    = '0;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
    end else if (!bus.stall) begin
      ctrl_next    = '0;
      valid_next   = 1'b0;
      illegal_next = 1'b0;
      unique case (state_reg)
        ST_RUN: begin
          if (acc) begin
            if (!dec_legal) begin
              illegal_next = TRAP_BIT;
            end else if (!(dec_mul && MUL_MULTI)) begin
              ctrl_next  = dec_ctrl;
              valid_next = 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (count_reg == 4'd0) begin
            ctrl_next  = mul_ctrl;
            valid_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output mapping
  // ------------------------------------------------------------------
  assign bus.instr_ready = instr_ready;
  assign bus.busy        = busy;
  assign bus.valid_out   = valid_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.reg_dst     = ctrl_reg.reg_dst;
  assign bus.reg_write   = ctrl_reg.reg_write;
  assign bus.alu_src     = ctrl_reg.alu_src;
  assign bus.mem_write   = ctrl_reg.mem_write;
  assign bus.mem_read    = ctrl_reg.mem_read;
  assign bus.branch      = ctrl_reg.branch;
  assign bus.mem_to_reg  = ctrl_reg.mem_to_reg;
  assign bus.sign_ext    = ctrl_reg.sign_ext;
  assign bus.alu_op      = ALUOP_W'(ctrl_reg.alu_op);
  assign bus.jump        = ctrl_reg.jump;
  assign bus.jump_mux    = ctrl_reg.jump_mux;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
//   Directed vectors against pipelined_control_unit (ALUOP_W=5,
//   MUL_CYCLES=4, TRAP_EN=1). Inputs change 1 ns after the rising edge and
//   registered outputs are sampled at that same point.
//   Bundle vectors are {reg_dst, reg_write, alu_src, mem_write, mem_read,
//   branch, mem_to_reg, sign_ext, alu_op, jump, jump_mux}.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

  localparam logic [16:0] B_NOP  = 17'b00_0_0_0_0_0_00_0_00000_0_0;
  localparam logic [16:0] B_LW   = 17'b01_1_1_0_1_0_01_1_00001_0_0;
  localparam logic [16:0] B_ADDI = 17'b01_1_1_0_0_0_00_1_00001_0_0;
  localparam logic [16:0] B_BEQ  = 17'b01_0_0_0_0_1_00_1_01110_0_0;
  localparam logic [16:0] B_JAL  = 17'b10_1_0_0_0_0_10_1_00000_1_0;
  localparam logic [16:0] B_SW   = 17'b01_0_1_1_0_0_01_1_00001_0_0;
  localparam logic [16:0] B_MUL  = 17'b00_1_0_0_0_0_00_1_01100_0_0;
  localparam logic [16:0] B_R    = 17'b00_1_0_0_0_0_00_1_00000_0_1;
  localparam logic [16:0] B_LUI  = 17'b01_1_1_0_0_0_00_0_10011_0_0;

  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_ADDI = 32'h2001_0005;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_MUL  = 32'h7022_1802;
  localparam logic [31:0] I_R    = 32'h0022_1820;
  localparam logic [31:0] I_LUI  = 32'h3C01_1234;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   nb;

  pipelined_control_unit_if #(.ALUOP_W(5)) bus ();

  pipelined_control_unit #(
    .ALUOP_W(5), .MUL_CYCLES(4), .TRAP_EN(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [16:0] obs();
    return {bus.reg_dst, bus.reg_write, bus.alu_src, bus.mem_write,
            bus.mem_read, bus.branch, bus.mem_to_reg, bus.sign_ext,
            bus.alu_op, bus.jump, bus.jump_mux};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle, then drop valid and check the bundle.
  task automatic issue_one(input string tag, input logic [31:0] ins,
                           input logic [16:0] exp_b);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check({tag, "_bundle"}, 32'(obs()), 32'(exp_b));
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;

    // T1 reset
    tick();
    tick();
    check("rst_bundle", 32'(obs()), 32'(B_NOP));
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(bus.instr_ready), 32'd1);
    tick();

    // T2 single LW
    issue_one("lw", I_LW, B_LW);
    tick();
    check("lw_after_valid", 32'(bus.valid_out), 32'd0);
    check("lw_after_bundle", 32'(obs()), 32'(B_NOP));

    // T3 back-to-back ADDI, BEQ, JAL
    bus.instr = I_ADDI; bus.instr_valid = 1'b1;
    tick();
    check("b2b_addi", 32'(obs()), 32'(B_ADDI));
    check("b2b_addi_v", 32'(bus.valid_out), 32'd1);
    bus.instr = I_BEQ;
    tick();
    check("b2b_beq", 32'(obs()), 32'(B_BEQ));
    check("b2b_beq_v", 32'(bus.valid_out), 32'd1);
    bus.instr = I_JAL;
    tick();
    check("b2b_jal", 32'(obs()), 32'(B_JAL));
    check("b2b_jal_v", 32'(bus.valid_out), 32'd1);
    bus.instr_valid = 1'b0;
    tick();
    check("b2b_end_v", 32'(bus.valid_out), 32'd0);

    // Extra decode rows
    issue_one("rtype", I_R, B_R);
    issue_one("lui", I_LUI, B_LUI);
    tick();

    // T4 MUL, ADDI held valid throughout
    bus.instr = I_MUL; bus.instr_valid = 1'b1;
    #1;
    check("mul_ready_pre", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr = I_ADDI;
    nb = 0;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      nb++;
      check("mul_busy_ready", 32'(bus.instr_ready), 32'd0);
      check("mul_busy_valid", 32'(bus.valid_out), 32'd0);
      tick();
    end
    check("mul_busy_cycles", 32'(nb), 32'd4);
    check("mul_bundle", 32'(obs()), 32'(B_MUL));
    check("mul_valid", 32'(bus.valid_out), 32'd1);
    check("mul_ready_post", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    check("mul_next_addi", 32'(obs()), 32'(B_ADDI));
    check("mul_next_addi_v", 32'(bus.valid_out), 32'd1);
    tick();

    // T5 stall holds an SW bundle for 3 cycles
    issue_one("sw", I_SW, B_SW);
    bus.stall = 1'b1;
    #1;
    check("stall_ready", 32'(bus.instr_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_sw_bundle", 32'(obs()), 32'(B_SW));
      check("stall_sw_valid", 32'(bus.valid_out), 32'd1);
    end
    bus.stall = 1'b0;
    tick();
    check("stall_rel_valid", 32'(bus.valid_out), 32'd0);

    // T5 stall mid-MUL stretches busy by 3 cycles
    bus.instr = I_MUL; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      nb++;
      bus.stall = (c >= 1 && c <= 3);
      tick();
    end
    bus.stall = 1'b0;
    check("mulstall_busy_cycles", 32'(nb), 32'd7);
    check("mulstall_bundle", 32'(obs()), 32'(B_MUL));
    check("mulstall_valid", 32'(bus.valid_out), 32'd1);
    tick();

    // T6 flush on cycle 2 of MUL, ADDI offered during the flush
    bus.instr = I_MUL; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("flush_c1_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.flush = 1'b1;
    bus.instr = I_ADDI; bus.instr_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.instr_valid = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_valid", 32'(bus.valid_out), 32'd0);
    check("flush_bundle", 32'(obs()), 32'(B_NOP));
    tick();
    check("flush_no_accept", 32'(bus.valid_out), 32'd0);

    // Flush in RUN: offered instruction is dropped, flush beats accept
    bus.flush = 1'b1;
    bus.instr = I_LW; bus.instr_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.instr_valid = 1'b0;
    check("flush_run_valid", 32'(bus.valid_out), 32'd0);
    check("flush_run_bundle", 32'(obs()), 32'(B_NOP));

    // Illegal opcode 0x3F
    bus.instr = I_BAD; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("illegal_pulse", 32'(bus.illegal), 32'd1);
    check("illegal_valid", 32'(bus.valid_out), 32'd0);
    check("illegal_bundle", 32'(obs()), 32'(B_NOP));
    tick();
    check("illegal_clear", 32'(bus.illegal), 32'd0);

    // Reset mid-MUL aborts the multiply
    bus.instr = I_MUL; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmul_busy", 32'(bus.busy), 32'd0);
    check("rstmul_valid", 32'(bus.valid_out), 32'd0);
    tick();
    check("rstmul_after_valid", 32'(bus.valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
